axi4_lite_sram: RTL
===================

Name: axi4_lite_sram

Overview:
AXI4-Lite slave memory model that sits directly downstream of the core's AXI4-Lite master and answers its read and write transactions. It holds a word-addressed SRAM array with byte-strobe writes. Read and write response latencies are programmable, with optional pseudo-random extra delay to stress master handshakes. Read and write channels operate independently and may be active concurrently.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two.
BASE_ADDR, 32'h8000_0000, byte address of word 0.
RD_LAT, 2, cycles from AR handshake to RVALID; must be >= 1.
WR_LAT, 2, cycles from capture of both AW and W to BVALID; must be >= 1.
RAND_EN, 0, 1 adds 0..3 extra cycles per transaction from a 4-bit LFSR.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
ARADDR  input  32  read address
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
RDATA  output  32  read data
RRESP  output  2  read response
RVALID  output  1  read data valid
RREADY  input  1  read data ready
AWADDR  input  32  write address
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
WDATA  input  32  write data
WSTRB  input  4  byte strobes
WVALID  input  1  write data valid
WREADY  output  1  write data ready
BRESP  output  2  write response
BVALID  output  1  write response valid
BREADY  input  1  write response ready

Behaviour:
- Reset: rst low asynchronously forces both FSMs to idle, clears the delay counters, and clears the captured address, data and strobe registers. While rst is low, RVALID=0, BVALID=0, RDATA=0, RRESP=0, BRESP=0, and ARREADY=AWREADY=WREADY=0. The LFSR reloads to 4'b1001. The memory array is not cleared. A transaction in flight when reset asserts is discarded with no response.
- Decode: offset = addr - BASE_ADDR. In range when offset < DEPTH*4. Word index = offset[log2(DEPTH)+1:2]. addr[1:0] is ignored. Out of range returns RESP=2'b11 (DECERR): reads return RDATA=0, and writes do not modify memory. In range returns RESP=2'b00.
- Read FSM, states R_IDLE, R_DELAY, R_RESP:
  - R_IDLE: ARREADY=1. When ARVALID&ARREADY, capture ARADDR, load the counter with RD_LAT-1 plus the random extra, and go to R_DELAY.
  - R_DELAY: ARREADY=0. Decrement the counter. When the counter is 0, sample memory into RDATA, set RRESP, and go to R_RESP.
  - R_RESP: RVALID=1. RDATA and RRESP hold stable until RVALID&RREADY, then return to R_IDLE.
  - With RAND_EN=0, RVALID rises exactly RD_LAT cycles after the AR handshake edge.
  - A new AR is accepted only in R_IDLE, so at most one read is outstanding.
- Write FSM, states W_IDLE, W_HAVE_AW, W_HAVE_W, W_DELAY, W_RESP:
  - AWREADY=1 in W_IDLE and W_HAVE_W. WREADY=1 in W_IDLE and W_HAVE_AW.
  - W_IDLE: AW and W in the same cycle go to W_DELAY. AW only goes to W_HAVE_AW. W only goes to W_HAVE_W.
  - W_HAVE_AW: W handshake goes to W_DELAY. W_HAVE_W: AW handshake goes to W_DELAY. Captured AWADDR, WDATA and WSTRB are held.
  - Entering W_DELAY loads the counter with WR_LAT-1 plus the random extra.
  - W_DELAY: when the counter is 0, commit the write (byte i written iff WSTRB[i] and in range), set BRESP, and go to W_RESP.
  - W_RESP: BVALID=1 and BRESP is stable until BVALID&BREADY, then return to W_IDLE.
  - WSTRB=0 commits nothing and still responds OKAY.
- Read/write collision: if the read sample and the write commit hit the same word on the same edge, the read returns the pre-write (old) data.
- The LFSR (x^4+x^3+1) advances every cycle. Random extra = lfsr[1:0], sampled at each counter load. With RAND_EN=0 the extra is 0.
- Valid signals never drop before their handshake completes. Response outputs are registered, with no combinational path from inputs.

Test Plan:
- Reset with RD_LAT=2: hold rst=0 for 3 cycles, then release, then AR 0x8000_0000 -> ARREADY=0 during reset; RVALID rises 2 cycles after the handshake with RDATA=0xXXXX (uninitialised, not checked) and RRESP=0.
- Write then read: AW+W same cycle, addr 0x8000_0010, WDATA=0xDEADBEEF, WSTRB=4'b1111 -> BVALID after 2 cycles with BRESP=0; a subsequent read of 0x8000_0010 returns 0xDEADBEEF.
- Split and partial write: W first (0x0000_00AA, WSTRB=4'b0001), AW 3 cycles later to 0x8000_0010 -> AWREADY=1 and WREADY=0 while in W_HAVE_W; a read then returns 0xDEADBEAA.
- Backpressure: hold RREADY=0 for 5 cycles after RVALID -> RVALID and RDATA stable throughout; ARREADY=0 until the handshake.
- Decode error: read 0x7FFF_FFFC and write 0x8000_1000 with DEPTH=1024 -> RRESP=2'b11 with RDATA=0, BRESP=2'b11, and memory unchanged.
- Mid-operation reset plus RAND_EN=1: assert rst during W_DELAY -> no BVALID and the FSM is idle after release; with RAND_EN=1, each RVALID latency falls within 2..5 cycles over 100 random reads.

Source files
------------

// File: rtl/axi4_lite_sram.sv
// ----------------------------------------------------------------------------
// axi4_lite_sram
//
// AXI4-Lite slave memory model. It answers the core's AXI4-Lite master from a
// word-addressed SRAM array and supports byte-strobe writes. The read and
// write channels run independently and may be busy at the same time. Response
// latency is programmable, and an optional pseudo-random extra delay can be
// added to stress the master's handshakes.
//
// Parameters
//   DEPTH     : number of 32-bit words (power of two)
//   BASE_ADDR : byte address of word 0
//   RD_LAT    : cycles from the AR handshake edge to RVALID (>= 1)
//   WR_LAT    : cycles from capturing both AW and W to BVALID (>= 1)
//   RAND_EN   : 1 adds 0..3 extra cycles per transaction, taken from an LFSR
//
// Ports
//   clk, rst                  : clock and asynchronous active-low reset
//   ARADDR/ARVALID/ARREADY    : read address channel
//   RDATA/RRESP/RVALID/RREADY : read data channel
//   AWADDR/AWVALID/AWREADY    : write address channel
//   WDATA/WSTRB/WVALID/WREADY : write data channel
//   BRESP/BVALID/BREADY       : write response channel
//   rd_state_dbg              : current read FSM state (0 idle, 1 delay, 2 resp)
//   wr_state_dbg              : current write FSM state (0 idle, 1 have_aw,
//                               2 have_w, 3 delay, 4 resp)
//
// Handshake semantics: a transfer happens on a rising edge where both VALID
// and READY are high. Once a VALID is raised, it and its payload stay stable
// until that edge. Every READY, VALID and response output here is driven by a
// register, so no input has a combinational path to an output.
// ----------------------------------------------------------------------------
module axi4_lite_sram #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned WR_LAT    = 2,
    parameter int unsigned RAND_EN   = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,

    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,

    output logic [1:0]  rd_state_dbg,
    output logic [2:0]  wr_state_dbg
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam int          CNT_W = 16;
    localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'd4;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_RESP  = 2'd2
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_HAVE_AW = 3'd1,
        W_HAVE_W  = 3'd2,
        W_DELAY   = 3'd3,
        W_RESP    = 3'd4
    } wr_state_t;

    rd_state_t rd_state;
    wr_state_t wr_state;

    logic [31:0] mem [DEPTH];

    logic [3:0]       lfsr;
    logic [CNT_W-1:0] rnd_extra;

    logic [CNT_W-1:0] rd_cnt;
    logic [31:0]      rd_addr;
    logic [31:0]      rd_off;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;

    logic [CNT_W-1:0] wr_cnt;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;
    logic [31:0]      wr_off;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_commit;

    logic ar_hs;
    logic aw_hs;
    logic w_hs;

    assign ar_hs = ARVALID && ARREADY;
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    assign rd_state_dbg = rd_state;
    assign wr_state_dbg = wr_state;

    // Address decode on the captured addresses. The subtraction wraps, so an
    // address below BASE_ADDR yields a huge offset and decodes out of range.
    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_in_range = ({1'b0, rd_off} < SPAN);
    assign rd_idx      = rd_off[IDX_W+1:2];

    assign wr_off      = wr_addr - BASE_ADDR;
    assign wr_in_range = ({1'b0, wr_off} < SPAN);
    assign wr_idx      = wr_off[IDX_W+1:2];

    // The write lands on the same edge that BVALID is raised.
    assign wr_commit = (wr_state == W_DELAY) && (wr_cnt == '0) && wr_in_range;

    assign rnd_extra = (RAND_EN != 0) ? {{(CNT_W-2){1'b0}}, lfsr[1:0]} : '0;

    // x^4 + x^3 + 1 Fibonacci LFSR. It free-runs every cycle, and both
    // channels sample it whenever they load their delay counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 4'b1001;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= R_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= '0;
            rd_cnt   <= '0;
            rd_addr  <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_addr  <= ARADDR;
                        rd_cnt   <= RD_LOAD + rnd_extra;
                        ARREADY  <= 1'b0;
                        rd_state <= R_DELAY;
                    end else begin
                        // Also raises ARREADY on the first cycle after reset.
                        ARREADY <= 1'b1;
                    end
                end
                R_DELAY: begin
                    if (rd_cnt == '0) begin
                        // A write that commits on this same edge is not
                        // seen here, so the read returns the old word.
                        if (rd_in_range) begin
                            RDATA <= mem[rd_idx];
                            RRESP <= RESP_OKAY;
                        end else begin
                            RDATA <= '0;
                            RRESP <= RESP_DECERR;
                        end
                        RVALID   <= 1'b1;
                        rd_state <= R_RESP;
                    end else begin
                        rd_cnt <= rd_cnt - 1'b1;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        RVALID   <= 1'b0;
                        ARREADY  <= 1'b1;
                        rd_state <= R_IDLE;
                    end
                end
                default: begin
                    ARREADY  <= 1'b0;
                    RVALID   <= 1'b0;
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state <= W_IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BRESP    <= '0;
            wr_cnt   <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_strb  <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_addr <= AWADDR;
                    end
                    if (w_hs) begin
                        wr_data <= WDATA;
                        wr_strb <= WSTRB;
                    end
                    if (aw_hs && w_hs) begin
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b0;
                        wr_cnt   <= WR_LOAD + rnd_extra;
                        wr_state <= W_DELAY;
                    end else if (aw_hs) begin
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b1;
                        wr_state <= W_HAVE_AW;
                    end else if (w_hs) begin
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b0;
                        wr_state <= W_HAVE_W;
                    end else begin
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                    end
                end
                W_HAVE_AW: begin
                    if (w_hs) begin
                        wr_data  <= WDATA;
                        wr_strb  <= WSTRB;
                        WREADY   <= 1'b0;
                        wr_cnt   <= WR_LOAD + rnd_extra;
                        wr_state <= W_DELAY;
                    end
                end
                W_HAVE_W: begin
                    if (aw_hs) begin
                        wr_addr  <= AWADDR;
                        AWREADY  <= 1'b0;
                        wr_cnt   <= WR_LOAD + rnd_extra;
                        wr_state <= W_DELAY;
                    end
                end
                W_DELAY: begin
                    if (wr_cnt == '0) begin
                        BRESP    <= wr_in_range ? RESP_OKAY : RESP_DECERR;
                        BVALID   <= 1'b1;
                        wr_state <= W_RESP;
                    end else begin
                        wr_cnt <= wr_cnt - 1'b1;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID   <= 1'b0;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: begin
                    AWREADY  <= 1'b0;
                    WREADY   <= 1'b0;
                    BVALID   <= 1'b0;
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Storage array. It has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule
